tlb_assoc: RTL

Parametrised fully-associative joint TLB, successor to the fixed 8-entry TLB in the MMU. It provides depth set by parameter, a per-entry valid bit, and registered dual-port lookup with multi-hit detection. It also owns a hardware Random counter for TLBWR and a sequential invalidate engine for full or per-ASID flush. It sits between the CP0 TLB instruction path (TLBWI/TLBWR/TLBR/TLBP) and the instruction/data address-translation stages.

---
 rtl/tlb_assoc.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_assoc.sv
// Fully-associative joint TLB with registered dual-port lookup, combinational read port,
// a Wired-aware Random counter for TLBWR and a sequential full / per-ASID invalidate walker.
module tlb_assoc #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned ASID_W = 8,
    localparam int unsigned IDX_W = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    // search port 0
    input  logic              s0_req,
    input  logic [18:0]       s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_found,
    output logic              s0_multi,
    output logic [IDX_W-1:0]  s0_index,
    output logic [19:0]       s0_pfn,
    output logic [2:0]        s0_c,
    output logic              s0_d,
    output logic              s0_v,
    // search port 1
    input  logic              s1_req,
    input  logic [18:0]       s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_found,
    output logic              s1_multi,
    output logic [IDX_W-1:0]  s1_index,
    output logic [19:0]       s1_pfn,
    output logic [2:0]        s1_c,
    output logic              s1_d,
    output logic              s1_v,
    // write port
    input  logic              we,
    input  logic              w_random,
    input  logic [IDX_W-1:0]  w_index,
    input  logic [18:0]       w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [19:0]       w_pfn0,
    input  logic [19:0]       w_pfn1,
    input  logic [2:0]        w_c0,
    input  logic [2:0]        w_c1,
    input  logic              w_d0,
    input  logic              w_d1,
    input  logic              w_v0,
    input  logic              w_v1,
    input  logic [15:0]       w_mask,
    // read port
    input  logic [IDX_W-1:0]  r_index,
    output logic [18:0]       r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [19:0]       r_pfn0,
    output logic [19:0]       r_pfn1,
    output logic [2:0]        r_c0,
    output logic [2:0]        r_c1,
    output logic              r_d0,
    output logic              r_d1,
    output logic              r_v0,
    output logic              r_v1,
    output logic [15:0]       r_mask,
    output logic              r_e,
    // Random / Wired
    input  logic [IDX_W-1:0]  wired,
    input  logic              wired_we,
    output logic [IDX_W-1:0]  random,
    // invalidate engine
    input  logic              inv_req,
    input  logic              inv_mode,
    input  logic [ASID_W-1:0] inv_asid,
    output logic              inv_busy,
    output logic              inv_done
);

    localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(TLBNUM - 1);

    typedef struct packed {
        logic [18:0]       vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [19:0]       pfn0;
        logic [19:0]       pfn1;
        logic [2:0]        c0;
        logic [2:0]        c1;
        logic              d0;
        logic              d1;
        logic              v0;
        logic              v1;
        logic [15:0]       mask;
    } entry_t;

    typedef struct packed {
        logic             found;
        logic             multi;
        logic [IDX_W-1:0] index;
        logic [19:0]      pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } res_t;

    typedef enum logic [1:0] {StIdle, StWalk, StDone} inv_state_e;

    entry_t            ent_q [TLBNUM];
    entry_t            ent_d [TLBNUM];
    logic [TLBNUM-1:0] e_q, e_d;
    res_t              res_q [2];
    res_t              res_d [2];
    logic [IDX_W-1:0]  random_q, random_d;
    inv_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              mode_q, mode_d;
    logic [ASID_W-1:0] inv_asid_q, inv_asid_d;

    logic              s_req  [2];
    logic [18:0]       s_vpn2 [2];
    logic              s_odd  [2];
    logic [ASID_W-1:0] s_asid [2];

    logic [IDX_W-1:0]  w_idx;
    entry_t            w_ent;
    logic              walk_clr;

    assign s_req[0]  = s0_req;
    assign s_req[1]  = s1_req;
    assign s_vpn2[0] = s0_vpn2;
    assign s_vpn2[1] = s1_vpn2;
    assign s_odd[0]  = s0_odd_page;
    assign s_odd[1]  = s1_odd_page;
    assign s_asid[0] = s0_asid;
    assign s_asid[1] = s1_asid;

    // TLBWR targets the Random value present during the write cycle.
    assign w_idx = w_random ? random_q : w_index;

    always_comb begin
        w_ent      = '0;
        w_ent.vpn2 = w_vpn2 & ~{3'b0, w_mask};
        w_ent.asid = w_asid;
        w_ent.g    = w_g;
        w_ent.pfn0 = w_pfn0 & ~{4'b0, w_mask};
        w_ent.pfn1 = w_pfn1 & ~{4'b0, w_mask};
        w_ent.c0   = w_c0;
        w_ent.c1   = w_c1;
        w_ent.d0   = w_d0;
        w_ent.d1   = w_d1;
        w_ent.v0   = w_v0;
        w_ent.v1   = w_v1;
        w_ent.mask = w_mask;
    end

    // Storage next-state: walker clear first so a same-index write overrides it.
    always_comb begin
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            ent_d[i] = ent_q[i];
        end
        e_d = e_q;
        if (walk_clr) begin
            e_d[ptr_q] = 1'b0;
        end
        if (we) begin
            ent_d[w_idx] = w_ent;
            e_d[w_idx]   = 1'b1;
        end
    end

    always_comb begin
        logic [TLBNUM-1:0] h;
        logic              got;
        entry_t            sel;
        for (int p = 0; p < 2; p++) begin
            res_d[p] = res_q[p];
            h        = '0;
            got      = 1'b0;
            sel      = '0;
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                h[i] = e_q[i]
                    && ((s_vpn2[p] & ~{3'b0, ent_q[i].mask}) == ent_q[i].vpn2)
                    && (ent_q[i].g || (ent_q[i].asid == s_asid[p]));
            end
            if (s_req[p]) begin
                res_d[p]       = '0;
                res_d[p].found = |h;
                res_d[p].multi = |(h & (h - 1'b1));
                for (int unsigned i = 0; i < TLBNUM; i++) begin
                    if (h[i] && !got) begin
                        res_d[p].index = IDX_W'(i);
                        got            = 1'b1;
                    end
                end
                if (got) begin
                    sel = ent_q[res_d[p].index];
                    res_d[p].pfn = (s_odd[p] ? sel.pfn1 : sel.pfn0) & ~{4'b0, sel.mask};
                    res_d[p].c   = s_odd[p] ? sel.c1 : sel.c0;
                    res_d[p].d   = s_odd[p] ? sel.d1 : sel.d0;
                    res_d[p].v   = s_odd[p] ? sel.v1 : sel.v0;
                end
            end
        end
    end

    // The <= compare also covers wired at or above the top index (counter pinned at MaxIdx).
    always_comb begin
        random_d = random_q - 1'b1;
        if (wired_we || (random_q <= wired)) begin
            random_d = MaxIdx;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        inv_asid_d = inv_asid_q;
        walk_clr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inv_req) begin
                    mode_d     = inv_mode;
                    inv_asid_d = inv_asid;
                    ptr_d      = '0;
                    state_d    = StWalk;
                end
            end
            StWalk: begin
                walk_clr = !mode_q
                    || (!ent_q[ptr_q].g && (ent_q[ptr_q].asid == inv_asid_q));
                if (ptr_q == MaxIdx) begin
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                ent_q[i] <= '0;
            end
            e_q        <= '0;
            res_q[0]   <= '0;
            res_q[1]   <= '0;
            random_q   <= MaxIdx;
            state_q    <= StIdle;
            ptr_q      <= '0;
            mode_q     <= 1'b0;
            inv_asid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                ent_q[i] <= ent_d[i];
            end
            e_q        <= e_d;
            res_q[0]   <= res_d[0];
            res_q[1]   <= res_d[1];
            random_q   <= random_d;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            inv_asid_q <= inv_asid_d;
        end
    end

    assign s0_found = res_q[0].found;
    assign s0_multi = res_q[0].multi;
    assign s0_index = res_q[0].index;
    assign s0_pfn   = res_q[0].pfn;
    assign s0_c     = res_q[0].c;
    assign s0_d     = res_q[0].d;
    assign s0_v     = res_q[0].v;
    assign s1_found = res_q[1].found;
    assign s1_multi = res_q[1].multi;
    assign s1_index = res_q[1].index;
    assign s1_pfn   = res_q[1].pfn;
    assign s1_c     = res_q[1].c;
    assign s1_d     = res_q[1].d;
    assign s1_v     = res_q[1].v;

    assign r_vpn2 = ent_q[r_index].vpn2;
    assign r_asid = ent_q[r_index].asid;
    assign r_g    = ent_q[r_index].g;
    assign r_pfn0 = ent_q[r_index].pfn0;
    assign r_pfn1 = ent_q[r_index].pfn1;
    assign r_c0   = ent_q[r_index].c0;
    assign r_c1   = ent_q[r_index].c1;
    assign r_d0   = ent_q[r_index].d0;
    assign r_d1   = ent_q[r_index].d1;
    assign r_v0   = ent_q[r_index].v0;
    assign r_v1   = ent_q[r_index].v1;
    assign r_mask = ent_q[r_index].mask;
    assign r_e    = e_q[r_index];

    assign random   = random_q;
    assign inv_busy = (state_q != StIdle);
    assign inv_done = (state_q == StDone);

endmodule
